// File: rtl/led_pattern_ctrl.sv
// Eight-pattern LED sequencer: synchronizes SW, reloads on mode change, steps LED once per DIV clocks.
// Optional LEDCTRL_GRAY_EN: mode 100 shows a Gray-coded counter instead of plain binary.
module led_pattern_ctrl #(
  parameter int DIV   = 25_000_000,
  parameter int DIV_W = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] SW,
  output logic [7:0] LED
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  localparam logic [2:0] M_OFF   = 3'd0;
  localparam logic [2:0] M_ROTL  = 3'd1;
  localparam logic [2:0] M_ROTR  = 3'd2;
  localparam logic [2:0] M_PING  = 3'd3;
  localparam logic [2:0] M_UP    = 3'd4;
  localparam logic [2:0] M_DOWN  = 3'd5;
  localparam logic [2:0] M_FILL  = 3'd6;
  localparam logic [2:0] M_BLINK = 3'd7;

  // Ping-pong direction: left walks toward LED[7].
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_t           state, state_nxt;
  logic [2:0]       sw_s1, sw_s2;
  logic [2:0]       mode_q, mode_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic             dir, dir_nxt;
  logic [7:0]       led_nxt;
  logic             tick;
  logic             mode_chg;

`ifdef LEDCTRL_GRAY_EN
  logic [7:0] cnt, cnt_nxt;
`endif

  function automatic logic [7:0] init_pat(input logic [2:0] m);
    logic [7:0] p;
    case (m)
      M_OFF:   p = 8'h00;
      M_ROTL:  p = 8'h01;
      M_ROTR:  p = 8'h80;
      M_PING:  p = 8'h01;
      M_UP:    p = 8'h00;
      M_DOWN:  p = 8'hFF;
      M_FILL:  p = 8'h00;
      M_BLINK: p = 8'hFF;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign mode_chg = (sw_s2 != mode_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1 <= 3'b000;
      sw_s2 <= 3'b000;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= 3'b000;
      presc  <= '0;
      dir    <= DIR_LEFT;
      LED    <= 8'h00;
`ifdef LEDCTRL_GRAY_EN
      cnt    <= 8'h00;
`endif
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      presc  <= presc_nxt;
      dir    <= dir_nxt;
      LED    <= led_nxt;
`ifdef LEDCTRL_GRAY_EN
      cnt    <= cnt_nxt;
`endif
    end
  end

  // A mode change wins over a coincident tick: the step is dropped and LOAD follows.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    presc_nxt = presc;
    dir_nxt   = dir;
    led_nxt   = LED;
`ifdef LEDCTRL_GRAY_EN
    cnt_nxt   = cnt;
`endif
    if (mode_chg) begin
      mode_nxt  = sw_s2;
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE: begin
          led_nxt = 8'h00;
        end
        S_LOAD: begin
          led_nxt   = init_pat(mode_q);
          presc_nxt = '0;
          dir_nxt   = DIR_LEFT;
`ifdef LEDCTRL_GRAY_EN
          cnt_nxt   = 8'h00;
`endif
          state_nxt = (mode_q == M_OFF) ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (!tick) begin
            presc_nxt = presc + DIV_W'(1);
          end else begin
            presc_nxt = '0;
            case (mode_q)
              M_ROTL: led_nxt = {LED[6:0], LED[7]};
              M_ROTR: led_nxt = {LED[0], LED[7:1]};
              M_PING: begin
                // Turn around on the step that lands on an end LED, so ends are not repeated.
                if (dir == DIR_LEFT) begin
                  led_nxt = {LED[6:0], 1'b0};
                  if (LED == 8'h40) dir_nxt = DIR_RIGHT;
                end else begin
                  led_nxt = {1'b0, LED[7:1]};
                  if (LED == 8'h02) dir_nxt = DIR_LEFT;
                end
              end
              M_UP: begin
`ifdef LEDCTRL_GRAY_EN
                cnt_nxt = cnt + 8'd1;
                led_nxt = cnt_nxt ^ {1'b0, cnt_nxt[7:1]};
`else
                led_nxt = LED + 8'd1;
`endif
              end
              M_DOWN:  led_nxt = LED - 8'd1;
              M_FILL:  led_nxt = (LED == 8'hFF) ? 8'h00 : {LED[6:0], 1'b1};
              M_BLINK: led_nxt = ~LED;
              default: led_nxt = 8'h00;
            endcase
          end
        end
        default: begin
          state_nxt = S_IDLE;
          led_nxt   = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: per-cycle expected LED values from a sequence model, checked by a monitor.
// Define LEDCTRL_GRAY_EN for both bench and RTL to exercise the Gray-coded mode 100.
module tb_led_pattern_ctrl;
  localparam int DIV   = 4;
  localparam int DIV_W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] SW;
  logic [7:0] LED;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  int prev_m = 0;
  int prev_k = 0;

  led_pattern_ctrl #(.DIV(DIV), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .SW  (SW),
    .LED (LED)
  );

  // ---------------- clock / cycle count ----------------
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Value shown n steps after a mode's initial pattern.
  function automatic logic [7:0] seq_val(input int m, input int n);
    int p;
    int g;
    case (m)
      1: return 8'(1 << (n % 8));
      2: return 8'(128 >> (n % 8));
      3: begin
        p = n % 14;
        return (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
      4: begin
        g = n % 256;
`ifdef LEDCTRL_GRAY_EN
        return 8'(g ^ (g >> 1));
`else
        return 8'(g);
`endif
      end
      5: return 8'(255 - (n % 256));
      6: begin
        p = n % 9;
        return (p == 0) ? 8'h00 : 8'((1 << p) - 1);
      end
      7: return ((n % 2) == 0) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // SW applied before edge k: init pattern after edge k+3, one step every DIV edges.
  function automatic logic [7:0] exp_at(input int m, input int k, input int c);
    int n;
    n = c - k - 3;
    if (n < 0) n = 0;
    return seq_val(m, n / DIV);
  endfunction

  task automatic push_exp(input int c, input logic [7:0] v);
    exp_cyc_q.push_back(c);
    exp_q.push_back(v);
  endtask

  // Old pattern keeps stepping through edge k+1; edge k+2 is the LOAD request, where any tick is dropped.
  task automatic push_segment(input int m, input int k, input int len);
    for (int c = k; c <= k + 1; c++) push_exp(c, exp_at(prev_m, prev_k, c));
    push_exp(k + 2, exp_at(prev_m, prev_k, k + 1));
    for (int c = k + 3; c < k + 3 + len; c++) push_exp(c, exp_at(m, k, c));
    prev_m = m;
    prev_k = k;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: LED=%h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int         c;
    logic [7:0] e;
    if (!rst) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        c = exp_cyc_q.pop_front();
        e = exp_q.pop_front();
        if (c == cyc) check($sformatf("led_seq_mode%0d", prev_m), LED, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic start_mode(input int m, input int len);
    int k;
    @(negedge clk);
    #1;
    SW = 3'(m);
    k  = cyc + 1;
    push_segment(m, k, len);
    repeat (len + 3) @(posedge clk);
  endtask

  initial begin
    int m;
    int len;
    int k;

    // Reset with SW off: LED dark and held.
    rst = 1'b1;
    SW  = 3'b000;
    #5;
    check("reset_led", LED, 8'h00);
    #20;
    rst = 1'b0;
    start_mode(0, 10);

    // Directed modes.
    start_mode(1, 9 * DIV);
    start_mode(3, 16 * DIV);
    start_mode(5, 258 * DIV);
    start_mode(4, 10 * DIV);

    // Fill reaches 07, then the mode-change edge lands exactly on the next tick.
    start_mode(6, 4 * DIV - 2);
    start_mode(7, 3 * DIV);

    // Rotate left up to LED==10, then reset between edges.
    start_mode(1, 4 * DIV + 1);
    @(negedge clk);
    #3;
    check("pre_reset_led", LED, 8'h10);
    rst = 1'b1;
    #1;
    check("async_reset_led", LED, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold_led", LED, 8'h00);
    #4;
    rst    = 1'b0;
    k      = cyc + 1;
    prev_m = 0;
    push_segment(1, k, 3 * DIV);
    repeat (3 * DIV + 3) @(posedge clk);

    // Random mode sequences with random dwell times.
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(0, 7);
      if (m == prev_m) m = (m + 1) % 8;
      len = $urandom_range(1, 8 * DIV + 3);
      start_mode(m, len);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
